glb_opsum_reader: RTL

GLB_OPSUM_READER -- requirements
Module: glb_opsum_reader

---
 rtl/glb_opsum_reader_pkg.sv | 20 ++
 rtl/opsum_skid_fifo.sv | 55 +++++
 rtl/glb_opsum_reader.sv | 137 +++++++++++++
 3 files changed

// File: rtl/glb_opsum_reader_pkg.sv
// Shared types and constants for the GLB output-partial-sum reader.
// Holds the controller state encoding and the GLB word access constants.
package glb_opsum_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

    localparam logic [3:0]  GLB_RE_WORD = 4'b1111;
    localparam logic [31:0] WORD_BYTES  = 32'd4;

    // Byte address of the word following a.
    function automatic logic [31:0] next_word_addr(input logic [31:0] a);
        return a + WORD_BYTES;
    endfunction

endpackage

// File: rtl/opsum_skid_fifo.sv
// Two-entry FIFO holding GLB read data until the stream consumer takes it.
// Push and pop may happen together; a push into a full FIFO without a pop is dropped.
module opsum_skid_fifo #(
    parameter int DATA_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [DATA_SIZE-1:0] push_data,
    input  logic                 pop,
    output logic [DATA_SIZE-1:0] head,
    output logic [1:0]           count
);

    logic [DATA_SIZE-1:0] mem_r [2];
    logic                 wr_ptr_r;
    logic                 rd_ptr_r;
    logic [1:0]           count_r;
    logic                 do_push_s;
    logic                 do_pop_s;

    // Qualify requests against the current occupancy.
    always_comb begin
        do_pop_s  = pop && (count_r != 2'd0);
        do_push_s = push && ((count_r != 2'd2) || do_pop_s);
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_r[0] <= {DATA_SIZE{1'b0}};
            mem_r[1] <= {DATA_SIZE{1'b0}};
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= ~wr_ptr_r;
            end
            if (do_pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;

endmodule

// File: rtl/glb_opsum_reader.sv
// Drains word_count consecutive 32-bit words from the GLB starting at base_addr
// and presents them as a ready/valid stream with a last marker and done pulse.
module glb_opsum_reader
    import glb_opsum_reader_pkg::*;
#(
    parameter int DATA_SIZE = 32,
    parameter int CNT_BITS  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [31:0]          base_addr,
    input  logic [CNT_BITS-1:0]  word_count,
    output logic [3:0]           glb_re,
    output logic [31:0]          glb_r_addr,
    input  logic [DATA_SIZE-1:0] glb_r_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_SIZE-1:0] out_data,
    output logic                 out_last,
    output logic                 busy,
    output logic                 done
);

    localparam logic [CNT_BITS-1:0] CNT_ZERO = {CNT_BITS{1'b0}};
    localparam logic [CNT_BITS-1:0] CNT_ONE  = {{(CNT_BITS-1){1'b0}}, 1'b1};

    state_t              state_r;
    logic [31:0]         addr_r;
    logic [CNT_BITS-1:0] cnt_r;
    logic [CNT_BITS-1:0] issued_r;
    logic [CNT_BITS-1:0] remain_r;
    logic                pend_r;
    logic                busy_r;
    logic                done_r;

    logic [1:0]          fifo_count_s;
    logic                pop_s;
    logic [2:0]          credit_s;
    logic                rd_en_s;

    // A new read may issue when its data is guaranteed a slot even if the consumer stalls;
    // the pop happening this cycle frees a slot, which keeps one word per cycle flowing.
    always_comb begin
        pop_s    = (fifo_count_s != 2'd0) && out_ready;
        credit_s = {1'b0, fifo_count_s} + {2'b00, pend_r} - {2'b00, pop_s};
        rd_en_s  = (state_r == READ) && (issued_r != cnt_r) &&
                   (fifo_count_s != 2'd2) && (credit_s < 3'd2);
    end

    // Transfer control: state, address/counters, busy and done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= IDLE;
            addr_r   <= 32'd0;
            cnt_r    <= CNT_ZERO;
            issued_r <= CNT_ZERO;
            remain_r <= CNT_ZERO;
            pend_r   <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            pend_r <= rd_en_s;
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        addr_r   <= base_addr;
                        cnt_r    <= word_count;
                        remain_r <= word_count;
                        issued_r <= CNT_ZERO;
                        busy_r   <= 1'b1;
                        if (word_count == CNT_ZERO) begin
                            state_r <= FIN;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= READ;
                        end
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                READ: begin
                    if (rd_en_s) begin
                        addr_r   <= next_word_addr(addr_r);
                        issued_r <= issued_r + CNT_ONE;
                        if ((issued_r + CNT_ONE) == cnt_r) begin
                            state_r <= DRAIN;
                        end
                    end
                    if (pop_s) begin
                        remain_r <= remain_r - CNT_ONE;
                    end
                end
                DRAIN: begin
                    if (pop_s) begin
                        remain_r <= remain_r - CNT_ONE;
                        if (remain_r == CNT_ONE) begin
                            state_r <= FIN;
                            done_r  <= 1'b1;
                        end
                    end
                end
                FIN: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    opsum_skid_fifo #(
        .DATA_SIZE (DATA_SIZE)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (pend_r),
        .push_data (glb_r_data),
        .pop       (pop_s),
        .head      (out_data),
        .count     (fifo_count_s)
    );

    assign glb_re     = rd_en_s ? GLB_RE_WORD : 4'b0000;
    assign glb_r_addr = addr_r;
    assign out_valid  = (fifo_count_s != 2'd0);
    assign out_last   = out_valid && (remain_r == CNT_ONE);
    assign busy       = busy_r;
    assign done       = done_r;

endmodule
